// File: rtl/m68k_vram_bridge.sv
// ============================================================================
// Module   : m68k_vram_bridge
// Brief    : fx68k async bus slave onto byte-wide VRAM port A (32 KB window)
// Revision : 1.0
// ============================================================================
`default_nettype none

module m68k_vram_bridge #(
   parameter logic [23:0] BASE_ADDR  = 24'h200000,
   parameter int          RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_as_n,
   input  logic        cpu_rw,
   input  logic        cpu_uds_n,
   input  logic        cpu_lds_n,
   input  logic [23:1] cpu_a,
   input  logic [15:0] cpu_dout,
   output logic [15:0] cpu_din,
   output logic        dtack_n,
   output logic        sel,
   output logic [14:0] vram_addr,
   output logic        vram_we,
   output logic        vram_re,
   output logic [7:0]  vram_din,
   input  logic [7:0]  vram_dout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RWAIT = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   logic [1:0]  state_q,   state_d;
   logic        armed_q,   armed_d;
   logic [14:1] addr_q,    addr_d;
   logic        rw_q,      rw_d;
   logic        upper_q,   upper_d;
   logic        lower_q,   lower_d;
   logic [15:0] wdata_q,   wdata_d;
   logic        lane_q,    lane_d;
   logic        dtack_n_q, dtack_n_d;
   logic        sel_q,     sel_d;
   logic [15:0] rdata_q,   rdata_d;
   logic [15:0] cpu_din_q, cpu_din_d;

   // Read-capture pipeline: one stage per clock of BRAM latency
   logic [RD_LATENCY-1:0] cap_v_q,    cap_v_d;
   logic [RD_LATENCY-1:0] cap_l_q,    cap_l_d;
   logic [RD_LATENCY-1:0] cap_last_q, cap_last_d;

   logic        w_hit;
   logic        w_start;
   logic        w_push;
   logic        w_last_lane;
   logic [15:0] w_rdata;

   assign w_hit       = (cpu_a[23:15] == BASE_ADDR[23:15]);
   assign w_start     = armed_q && !cpu_as_n && w_hit && (!cpu_uds_n || !cpu_lds_n);
   assign w_last_lane = lane_q || !lower_q;
   assign w_push      = (state_q == S_ISSUE) && rw_q && !cpu_as_n;
   assign w_rdata     = cap_l_q[RD_LATENCY-1] ? {rdata_q[15:8], vram_dout}
                                              : {vram_dout, rdata_q[7:0]};

   always_comb begin
      state_d    = state_q;
      armed_d    = armed_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      upper_d    = upper_q;
      lower_d    = lower_q;
      wdata_d    = wdata_q;
      lane_d     = lane_q;
      dtack_n_d  = dtack_n_q;
      sel_d      = sel_q;
      rdata_d    = rdata_q;
      cpu_din_d  = cpu_din_q;
      cap_v_d    = cap_v_q;
      cap_l_d    = cap_l_q;
      cap_last_d = cap_last_q;

      for (int i = RD_LATENCY - 1; i > 0; i--) begin
         cap_v_d[i]    = cap_v_q[i-1];
         cap_l_d[i]    = cap_l_q[i-1];
         cap_last_d[i] = cap_last_q[i-1];
      end
      cap_v_d[0]    = w_push;
      cap_l_d[0]    = lane_q;
      cap_last_d[0] = w_last_lane;

      if (cpu_as_n) begin
         armed_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (w_start) begin
               state_d = S_ISSUE;
               addr_d  = cpu_a[14:1];
               rw_d    = cpu_rw;
               upper_d = !cpu_uds_n;
               lower_d = !cpu_lds_n;
               wdata_d = cpu_dout;
               lane_d  = cpu_uds_n;
               sel_d   = 1'b1;
               armed_d = 1'b0;
               rdata_d = 16'hFFFF;
            end
         end
         S_ISSUE: begin
            if (cpu_as_n) begin
               state_d   = S_IDLE;
               sel_d     = 1'b0;
               dtack_n_d = 1'b1;
               cap_v_d   = '0;
            end else if (!lane_q && lower_q) begin
               lane_d = 1'b1;
            end else if (rw_q) begin
               state_d = S_RWAIT;
            end else begin
               state_d   = S_ACK;
               dtack_n_d = 1'b0;
            end
         end
         S_RWAIT: begin
            if (cpu_as_n) begin
               state_d   = S_IDLE;
               sel_d     = 1'b0;
               dtack_n_d = 1'b1;
               cap_v_d   = '0;
            end
         end
         default: begin
            if (cpu_as_n) begin
               state_d   = S_IDLE;
               sel_d     = 1'b0;
               dtack_n_d = 1'b1;
            end
         end
      endcase

      // An earlier lane may land while the next lane is still being issued
      if ((state_q == S_ISSUE || state_q == S_RWAIT) && !cpu_as_n && cap_v_q[RD_LATENCY-1]) begin
         rdata_d = w_rdata;
         if (cap_last_q[RD_LATENCY-1]) begin
            cpu_din_d = w_rdata;
            dtack_n_d = 1'b0;
            state_d   = S_ACK;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         armed_q    <= 1'b1;
         addr_q     <= '0;
         rw_q       <= 1'b1;
         upper_q    <= 1'b0;
         lower_q    <= 1'b0;
         wdata_q    <= '0;
         lane_q     <= 1'b0;
         dtack_n_q  <= 1'b1;
         sel_q      <= 1'b0;
         rdata_q    <= 16'hFFFF;
         cpu_din_q  <= 16'hFFFF;
         cap_v_q    <= '0;
         cap_l_q    <= '0;
         cap_last_q <= '0;
      end else begin
         state_q    <= state_d;
         armed_q    <= armed_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         upper_q    <= upper_d;
         lower_q    <= lower_d;
         wdata_q    <= wdata_d;
         lane_q     <= lane_d;
         dtack_n_q  <= dtack_n_d;
         sel_q      <= sel_d;
         rdata_q    <= rdata_d;
         cpu_din_q  <= cpu_din_d;
         cap_v_q    <= cap_v_d;
         cap_l_q    <= cap_l_d;
         cap_last_q <= cap_last_d;
      end
   end

   // Pulses come straight from state so an abort never truncates a lane
   assign vram_we   = (state_q == S_ISSUE) && !rw_q;
   assign vram_re   = (state_q == S_ISSUE) && rw_q;
   assign vram_addr = {addr_q, lane_q};
   assign vram_din  = lane_q ? wdata_q[7:0] : wdata_q[15:8];
   assign cpu_din   = cpu_din_q;
   assign dtack_n   = dtack_n_q;
   assign sel       = sel_q;

   logic w_unused;
   assign w_unused = upper_q;

endmodule

`default_nettype wire

// File: tb/tb_m68k_vram_bridge.sv
// ============================================================================
// Module   : tb_m68k_vram_bridge
// Brief    : scoreboard bench for m68k_vram_bridge with a registered VRAM model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_m68k_vram_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_as_n = 1'b1;
   logic        cpu_rw = 1'b1;
   logic        cpu_uds_n = 1'b1;
   logic        cpu_lds_n = 1'b1;
   logic [23:1] cpu_a = '0;
   logic [15:0] cpu_dout = '0;
   logic [15:0] cpu_din;
   logic        dtack_n;
   logic        sel;
   logic [14:0] vram_addr;
   logic        vram_we;
   logic        vram_re;
   logic [7:0]  vram_din;
   logic [7:0]  vram_dout = 8'h00;

   m68k_vram_bridge #(.BASE_ADDR(24'h200000), .RD_LATENCY(1)) dut (
      .clk(clk), .reset(reset), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
      .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_a(cpu_a),
      .cpu_dout(cpu_dout), .cpu_din(cpu_din), .dtack_n(dtack_n), .sel(sel),
      .vram_addr(vram_addr), .vram_we(vram_we), .vram_re(vram_re),
      .vram_din(vram_din), .vram_dout(vram_dout)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [0:32767];
   int          n_chk = 0;
   int          n_fail = 0;
   int          we_cnt = 0;
   int          re_cnt = 0;
   bit          dtack_seen = 1'b0;
   logic [22:0] wr_q [$];
   logic [15:0] rd_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      if (vram_we) mem[vram_addr] <= vram_din;
      if (vram_re) vram_dout <= mem[vram_addr];
   end

   always @(negedge clk) begin
      logic [22:0] e;
      if (vram_we || vram_re) check("we_re_exclusive", {31'd0, vram_we & vram_re}, 32'd0);
      if (vram_we) begin
         we_cnt++;
         check("we_expected", {31'd0, wr_q.size() != 0}, 32'd1);
         if (wr_q.size() != 0) begin
            e = wr_q.pop_front();
            check("we_addr", {17'd0, vram_addr}, {17'd0, e[22:8]});
            check("we_data", {24'd0, vram_din}, {24'd0, e[7:0]});
         end
      end
      if (vram_re) re_cnt++;
      if (!dtack_n) dtack_seen = 1'b1;
   end

   // One complete bus cycle; write cycles spend one clock with both strobes high
   task automatic access(input string tag, input logic [23:0] ba, input bit rw,
                         input bit u, input bit l, input logic [15:0] wd,
                         input int exp_lat, input logic [15:0] exp_rd);
      int k;
      @(negedge clk);
      cpu_a  = ba[23:1];
      cpu_rw = rw;
      cpu_as_n = 1'b0;
      if (!rw) begin
         cpu_uds_n = 1'b1;
         cpu_lds_n = 1'b1;
         @(negedge clk);
         check({tag, "_wait_sel"}, {31'd0, sel}, 32'd0);
         cpu_dout = wd;
         if (u) wr_q.push_back({ba[14:1], 1'b0, wd[15:8]});
         if (l) wr_q.push_back({ba[14:1], 1'b1, wd[7:0]});
      end else begin
         rd_q.push_back(exp_rd);
      end
      cpu_uds_n = !u;
      cpu_lds_n = !l;
      k = 99;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!dtack_n) begin
            k = i;
            break;
         end
      end
      check({tag, "_latency"}, k, exp_lat);
      if (rw && rd_q.size() != 0) check({tag, "_rdata"}, {16'd0, cpu_din}, {16'd0, rd_q.pop_front()});
      @(negedge clk);
      check({tag, "_hold"}, {31'd0, dtack_n}, 32'd0);
      if (rw) check({tag, "_din_stable"}, {16'd0, cpu_din}, {16'd0, exp_rd});
      cpu_as_n  = 1'b1;
      cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1;
      @(negedge clk);
      check({tag, "_release"}, {30'd0, dtack_n, sel}, {30'd0, 1'b1, 1'b0});
   endtask

   task automatic miss(input string tag, input logic [23:0] ba);
      int we0, re0;
      we0 = we_cnt;
      re0 = re_cnt;
      dtack_seen = 1'b0;
      @(negedge clk);
      cpu_a = ba[23:1];
      cpu_rw = 1'b1;
      cpu_as_n = 1'b0;
      cpu_uds_n = 1'b0;
      cpu_lds_n = 1'b0;
      repeat (6) @(negedge clk);
      check({tag, "_sel"}, {31'd0, sel}, 32'd0);
      check({tag, "_no_dtack"}, {31'd0, dtack_seen}, 32'd0);
      check({tag, "_no_pulses"}, we_cnt + re_cnt, we0 + re0);
      cpu_as_n = 1'b1;
      cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int re0, we0;
      for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
      mem[15'h0100] = 8'h5A;
      mem[15'h0101] = 8'hC3;

      cpu_a = 23'h100000;
      cpu_rw = 1'b0;
      cpu_as_n = 1'b0;
      cpu_uds_n = 1'b0;
      cpu_lds_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dtack", {31'd0, dtack_n}, 32'd1);
      check("rst_sel", {31'd0, sel}, 32'd0);
      check("rst_pulses", {30'd0, vram_we, vram_re}, 32'd0);
      check("rst_cpu_din", {16'd0, cpu_din}, 32'h0000FFFF);
      check("rst_vram_bus", {9'd0, vram_addr, vram_din}, 32'd0);
      check("rst_pulse_count", we_cnt + re_cnt, 0);
      cpu_as_n = 1'b1;
      cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1;
      cpu_rw = 1'b1;
      reset = 1'b0;
      @(negedge clk);

      access("byte_wr", 24'h200010, 1'b0, 1'b1, 1'b0, 16'hAB12, 2, 16'h0);
      access("word_wr", 24'h207FFE, 1'b0, 1'b1, 1'b1, 16'h1234, 3, 16'h0);

      re0 = re_cnt;
      access("word_rd", 24'h200100, 1'b1, 1'b1, 1'b1, 16'h0, 4, 16'h5AC3);
      access("lds_rd", 24'h200101, 1'b1, 1'b0, 1'b1, 16'h0, 3, 16'hFFC3);
      access("uds_rd", 24'h207FFE, 1'b1, 1'b1, 1'b0, 16'h0, 3, 16'h12FF);
      access("word_rd_back", 24'h207FFE, 1'b1, 1'b1, 1'b1, 16'h0, 4, 16'h1234);
      check("read_pulses", re_cnt - re0, 6);

      miss("miss_low", 24'h000100);
      miss("miss_high", 24'h208000);

      // Abort: AS released right after E0 of a word write
      we0 = we_cnt;
      dtack_seen = 1'b0;
      @(negedge clk);
      cpu_a = 23'h100100;
      cpu_rw = 1'b0;
      cpu_dout = 16'h1234;
      cpu_as_n = 1'b0;
      cpu_uds_n = 1'b0;
      cpu_lds_n = 1'b0;
      wr_q.push_back({14'h0100, 1'b0, 8'h12});
      @(negedge clk);
      check("abort_sel", {31'd0, sel}, 32'd1);
      cpu_as_n = 1'b1;
      cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1;
      repeat (5) @(negedge clk);
      check("abort_we_count", we_cnt - we0, 1);
      check("abort_no_dtack", {31'd0, dtack_seen}, 32'd0);
      check("abort_sel_clear", {31'd0, sel}, 32'd0);
      check("abort_queue", wr_q.size(), 0);
      check("abort_mem_lo", {24'd0, mem[15'h0201]}, 32'd0);

      // Back-to-back reads separated by a single AS-high clock
      re0 = re_cnt;
      access("b2b_rd1", 24'h200100, 1'b1, 1'b1, 1'b1, 16'h0, 4, 16'h5AC3);
      access("b2b_rd2", 24'h200101, 1'b1, 1'b0, 1'b1, 16'h0, 3, 16'hFFC3);
      check("b2b_pulses", re_cnt - re0, 3);
      check("final_wr_queue", wr_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/m68k_vram_bridge.md
Name: m68k_vram_bridge

Overview:
Bus slave that connects the fx68k asynchronous bus (AS/UDS/LDS/RW/DTACK) to port A of the byte-wide video RAM (vram, 32 KB).
- Decodes a 32 KB window, splits 16-bit accesses into big-endian byte cycles and generates DTACK.
- Sits between the CPU and video_ram; the top level muxes cpu_din and ANDs dtack_n using sel.
- Runs on clk_cpu at full rate, independent of the phi1/phi2 enables.

Parameters:
BASE_ADDR, 24'h200000, byte base address of the window; only bits [23:15] are compared.
RD_LATENCY, 1, clocks from vram_re/addr presented to valid vram_dout (1 = registered BRAM output); legal range 1..3.

Ports:
clk  in  1  CPU clock (clk_cpu)
reset  in  1  asynchronous, active-high
cpu_as_n  in  1  address strobe
cpu_rw  in  1  1 = read, 0 = write
cpu_uds_n  in  1  upper byte strobe (D15:8, even address)
cpu_lds_n  in  1  lower byte strobe (D7:0, odd address)
cpu_a  in  23  word address [23:1]
cpu_dout  in  16  CPU write data
cpu_din  out  16  read data to CPU
dtack_n  out  1  data transfer acknowledge, active low
sel  out  1  window access in progress
vram_addr  out  15  vram byte address
vram_we  out  1  one-cycle write pulse
vram_re  out  1  one-cycle read pulse
vram_din  out  8  vram write data
vram_dout  in  8  vram read data

Behaviour:
- Reset (async): state IDLE, dtack_n=1, sel=0, vram_we=0, vram_re=0, vram_addr=0, vram_din=0, cpu_din=16'hFFFF, armed=1.
- Hit condition: cpu_a[23:15]==BASE_ADDR[23:15]. Misses are ignored entirely: no vram activity, sel=0, dtack_n=1.
- Request accept at edge E0: armed=1, as_n=0, hit, and at least one of uds_n/lds_n low.
  - AS low with both strobes high (68k write, first clock) keeps the block waiting in IDLE.
  - At E0: latch cpu_a[14:1], rw, lanes and cpu_dout; set sel=1 and armed=0.
- States: IDLE -> ISSUE -> (READ_WAIT) -> ACK -> IDLE.
- ISSUE:
  - Lanes are issued upper first, one per cycle.
  - vram_addr={a[14:1],0} for upper, {a[14:1],1} for lower.
  - Write: vram_we=1, vram_din=latched byte.
  - Read: vram_re=1.
  - Lanes are issued in consecutive cycles starting in the cycle after E0.
- Read capture: each byte is captured from vram_dout RD_LATENCY+1 edges after its issue edge. A lane not strobed reads as 8'hFF.
- DTACK timing: dtack_n goes low and cpu_din is updated on the edge of the last write issue or last read capture. With RD_LATENCY=1:
  - byte write: low after E1
  - word write: low after E2
  - byte read: low after E2
  - word read: low after E3
- ACK: dtack_n=0 and cpu_din held stable until as_n is sampled high. At that edge: dtack_n=1, sel=0, armed=1, state IDLE.
- Re-arm: a new cycle is only accepted after as_n has been sampled high at least once (armed), so back-to-back cycles never double-issue.
- Abort: if as_n is sampled high before ACK, stop issuing further lanes. An in-flight pulse is not retracted. Return to IDLE with dtack_n=1, sel=0, armed=1. Pending read captures are discarded.
- Strobe/address changes after E0 are ignored; latched values are used.
- vram_we and vram_re are never high together and never high for more than one cycle per lane.
- Reset mid-operation: all outputs take reset values immediately; a partially issued word write may leave one byte written.

Test Plan:
1. Reset -> dtack_n=1, sel=0, vram_we=0, vram_re=0, cpu_din=16'hFFFF; hold reset for 3 clocks with as_n low on a hit -> no vram pulses.
2. Byte write: byte addr 0x200010, uds_n=0 one clock after as_n=0, cpu_dout=16'hAB12 -> single vram_we at addr 0x0010, din 0xAB; dtack_n low after E1, held until as_n high, then 1 on the next edge.
3. Word write: 0x207FFE, cpu_dout=16'h1234 -> vram_we at 0x7FFE/0x12 then 0x7FFF/0x34 on consecutive cycles; dtack_n low after E2.
4. Word read: vram model preloaded 0x0100=0x5A, 0x0101=0xC3, RD_LATENCY=1 -> cpu_din=16'h5AC3 with dtack_n low after E3. Repeat LDS-only read at byte 0x0101 -> cpu_din=16'hFFC3.
5. Miss at 0x000100 and 0x208000 -> no vram_we/vram_re, sel=0, dtack_n stays 1.
6. Abort: as_n high one clock after E0 during word write -> exactly one vram_we (0x12), dtack_n never low. Back-to-back reads with as_n high for one clock -> two independent acknowledged cycles, no extra pulses.
